multicycle_main_control: RTL and testbench

//  Main control FSM for the multi-cycle RV32I subset core (lw, sw, R-type add/sub/and/or, beq).

---
 rtl/multicycle_main_control.sv | 174 +++++++++++++++++
 tb/tb_multicycle_main_control.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle RV32I subset core (lw, sw, add/sub/and/or, beq).
// Datapath enables are registered from the next state; ir/pc write and illegal follow mem_ready/opcode live.
module multicycle_main_control #(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXEC     = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    HALT     = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;
  logic   retire;
  logic   op_legal;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read = 1'b1;
        c.alusrcb  = 2'b01;
      end
      DECODE: c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMREAD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEMWRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      ALUWB: c.reg_write = 1'b1;
      BRANCH: begin
        c.alusrca       = 1'b1;
        c.aluop         = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pcsource      = 2'b01;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign op_legal = (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_RTYP) || (opcode == OP_BEQ);

  always_comb begin
    nxt    = IDLE;
    retire = 1'b0;
    case (state)
      IDLE:    nxt = FETCH;
      FETCH:   nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYP:      nxt = EXEC;
          OP_BEQ:       nxt = BRANCH;
          default:      nxt = ILLEGAL_HALT ? HALT : FETCH;
        endcase
      end
      MEMADR:  nxt = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD: nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWB: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      MEMWRITE: begin
        nxt    = mem_ready ? FETCH : MEMWRITE;
        retire = mem_ready;
      end
      EXEC:    nxt = ALUWB;
      ALUWB, BRANCH: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      HALT:    nxt = HALT;
      default: nxt = IDLE;
    endcase
  end

  // Control word is precomputed from the next state so it lines up with state_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ctrl      <= '0;
      instret_o <= '0;
    end else begin
      state <= nxt;
      ctrl  <= decode(nxt);
      if (retire) begin
        instret_o <= instret_o + CNT_W'(1);
      end
    end
  end

  assign pc_write      = (state == FETCH) && mem_ready;
  assign ir_write      = (state == FETCH) && mem_ready;
  assign illegal       = (state == DECODE) && !op_legal;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alusrca       = ctrl.alusrca;
  assign alusrcb       = ctrl.alusrcb;
  assign aluop         = ctrl.aluop;
  assign pcsource      = ctrl.pcsource;
  assign state_o       = state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: a 4-bit-counter resume instance and a halting instance
// share stimulus and are both tracked by an instruction-route model.
module tb_multicycle_main_control;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ILL  = 7'b0010011;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_ready;
  logic [6:0] opcode;

  logic pc_write_a, pc_write_cond_a, ir_write_a, iord_a, mem_read_a, mem_write_a;
  logic mem_to_reg_a, reg_write_a, alusrca_a, illegal_a;
  logic [1:0] alusrcb_a, aluop_a, pcsource_a;
  logic [3:0] state_a;
  logic [3:0] instret_a;

  logic pc_write_b, pc_write_cond_b, ir_write_b, iord_b, mem_read_b, mem_write_b;
  logic mem_to_reg_b, reg_write_b, alusrca_b, illegal_b;
  logic [1:0] alusrcb_b, aluop_b, pcsource_b;
  logic [3:0] state_b;
  logic [31:0] instret_b;

  multicycle_main_control #(.CNT_W(4), .ILLEGAL_HALT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_a), .pc_write_cond(pc_write_cond_a), .ir_write(ir_write_a),
    .iord(iord_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
    .mem_to_reg(mem_to_reg_a), .reg_write(reg_write_a), .alusrca(alusrca_a),
    .alusrcb(alusrcb_a), .aluop(aluop_a), .pcsource(pcsource_a),
    .illegal(illegal_a), .state_o(state_a), .instret_o(instret_a)
  );

  multicycle_main_control #(.CNT_W(32), .ILLEGAL_HALT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b), .ir_write(ir_write_b),
    .iord(iord_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
    .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b), .alusrca(alusrca_b),
    .alusrcb(alusrcb_b), .aluop(aluop_b), .pcsource(pcsource_b),
    .illegal(illegal_b), .state_o(state_b), .instret_o(instret_b)
  );

  always #5 clk = ~clk;

  logic [15:0] ctrl_a, ctrl_b;
  assign ctrl_a = {pc_write_a, pc_write_cond_a, ir_write_a, iord_a, mem_read_a, mem_write_a,
                   mem_to_reg_a, reg_write_a, alusrca_a, alusrcb_a, aluop_a, pcsource_a, illegal_a};
  assign ctrl_b = {pc_write_b, pc_write_cond_b, ir_write_b, iord_b, mem_read_b, mem_write_b,
                   mem_to_reg_b, reg_write_b, alusrca_b, alusrcb_b, aluop_b, pcsource_b, illegal_b};

  int checks = 0;
  int failures = 0;

  // Each instruction class walks a fixed list of states from FETCH; class 4 is illegal.
  int route_tab [4][5] = '{'{1, 2, 3, 4, 5}, '{1, 2, 3, 6, 0}, '{1, 2, 7, 8, 0}, '{1, 2, 9, 0, 0}};
  int route_len [4]    = '{5, 4, 4, 3};

  int          m_st  [2];
  int          m_cls [2];
  int          m_ph  [2];
  logic [31:0] m_cnt [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  function automatic int classify(input logic [6:0] op);
    case (op)
      OP_LW:   return 0;
      OP_SW:   return 1;
      OP_R:    return 2;
      OP_BEQ:  return 3;
      default: return 4;
    endcase
  endfunction

  // Bit order: pc_write pc_write_cond ir_write iord mem_read mem_write mem_to_reg reg_write
  //            alusrca alusrcb[2] aluop[2] pcsource[2] illegal
  function automatic logic [15:0] exp_ctrl(input int st, input logic mr, input logic [6:0] op);
    logic [15:0] v;
    v = '0;
    case (st)
      1: begin v[15] = mr; v[13] = mr; v[11] = 1'b1; v[6:5] = 2'b01; end
      2: begin v[6:5] = 2'b11; v[0] = (classify(op) == 4); end
      3: begin v[7] = 1'b1; v[6:5] = 2'b10; end
      4: begin v[11] = 1'b1; v[12] = 1'b1; end
      5: begin v[8] = 1'b1; v[9] = 1'b1; end
      6: begin v[10] = 1'b1; v[12] = 1'b1; end
      7: begin v[7] = 1'b1; v[4:3] = 2'b10; end
      8: v[8] = 1'b1;
      9: begin v[7] = 1'b1; v[4:3] = 2'b01; v[14] = 1'b1; v[2:1] = 2'b01; end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Predicts the state after the coming rising edge from the inputs now applied.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_st[i]  = 0;
        m_cnt[i] = 0;
      end else if (m_st[i] == 0) begin
        m_st[i] = 1;
      end else if (m_st[i] == 10) begin
        m_st[i] = 10;
      end else if ((m_st[i] == 1 || m_st[i] == 4 || m_st[i] == 6) && !mem_ready) begin
        m_st[i] = m_st[i];
      end else if (m_st[i] == 1) begin
        m_st[i] = 2;
      end else if (m_st[i] == 2) begin
        m_cls[i] = classify(opcode);
        if (m_cls[i] == 4) begin
          m_st[i] = (i == 1) ? 10 : 1;
        end else begin
          m_ph[i] = 2;
          m_st[i] = route_tab[m_cls[i]][2];
        end
      end else begin
        m_ph[i] = m_ph[i] + 1;
        if (m_ph[i] == route_len[m_cls[i]]) begin
          m_st[i]  = 1;
          m_cnt[i] = (i == 0) ? ((m_cnt[i] + 1) & 32'hF) : (m_cnt[i] + 1);
        end else begin
          m_st[i] = route_tab[m_cls[i]][m_ph[i]];
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("state_a",   32'(state_a),   32'(m_st[0]));
    chk("ctrl_a",    32'(ctrl_a),    32'(exp_ctrl(m_st[0], mem_ready, opcode)));
    chk("instret_a", 32'(instret_a), m_cnt[0]);
    chk("state_b",   32'(state_b),   32'(m_st[1]));
    chk("ctrl_b",    32'(ctrl_b),    32'(exp_ctrl(m_st[1], mem_ready, opcode)));
    chk("instret_b", instret_b,      m_cnt[1]);
  endtask

  task automatic cyc(input logic mr, input logic [6:0] op);
    mem_ready = mr;
    opcode    = op;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  logic [6:0] ill_list [4] = '{7'b0010011, 7'b1101111, 7'b0000000, 7'b1111111};

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = OP_R;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_cls[i] = 0; m_ph[i] = 0; m_cnt[i] = 0;
    end
    #3;
    compare_all();
    chk("reset_state", 32'(state_a), 32'd0);
    chk("reset_ctrl", 32'(ctrl_a), 32'd0);

    // Release and one R-type with no wait states.
    @(negedge clk);
    rst_n = 1'b1;
    chk("idle_after_release", 32'(state_a), 32'd0);
    cyc(1'b1, OP_R); chk("seq_fetch", 32'(state_a), 32'd1);
    cyc(1'b1, OP_R); chk("seq_decode", 32'(state_a), 32'd2);
    cyc(1'b1, OP_R); chk("exec_aluop", 32'(aluop_a), 32'd2);
    cyc(1'b1, OP_R); chk("aluwb_reg_write", 32'(reg_write_a), 32'd1);
    cyc(1'b1, OP_R); chk("rtype_retired", 32'(instret_a), 32'd1);

    // lw with three wait cycles in MEMREAD.
    cyc(1'b1, OP_LW);
    cyc(1'b1, OP_LW);
    cyc(1'b1, OP_LW); chk("lw_memread_enter", 32'(state_a), 32'd4);
    cyc(1'b0, OP_LW);
    cyc(1'b0, OP_LW);
    cyc(1'b0, OP_LW); chk("lw_memread_held", 32'(state_a), 32'd4);
    cyc(1'b1, OP_LW); chk("lw_memwb_mem_to_reg", 32'(mem_to_reg_a), 32'd1);
    cyc(1'b1, OP_LW); chk("lw_retired", 32'(instret_a), 32'd2);

    // beq.
    cyc(1'b1, OP_BEQ);
    cyc(1'b1, OP_BEQ);
    chk("beq_ctrl", {26'd0, aluop_a, pc_write_cond_a, pcsource_a, state_a == 4'd9},
        {26'd0, 2'b01, 1'b1, 2'b01, 1'b1});
    cyc(1'b1, OP_BEQ); chk("beq_back_to_fetch", 32'(state_a), 32'd1);
    chk("beq_retired", 32'(instret_a), 32'd3);

    // sw interrupted by reset while stalled.
    cyc(1'b1, OP_SW);
    cyc(1'b1, OP_SW);
    cyc(1'b0, OP_SW); chk("sw_mem_write", 32'(mem_write_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_mem_write_drop", 32'(mem_write_a), 32'd0);
    chk("async_state", 32'(state_a), 32'd0);
    chk("async_instret", 32'(instret_a), 32'd0);
    cyc(1'b0, OP_SW);
    rst_n = 1'b1;

    // Illegal opcode: resume instance vs halting instance.
    cyc(1'b1, OP_ILL);
    cyc(1'b1, OP_ILL);
    chk("illegal_pulse", {30'd0, illegal_a, illegal_b}, 32'd3);
    cyc(1'b1, OP_ILL);
    chk("illegal_resume", 32'(state_a), 32'd1);
    chk("illegal_halt", 32'(state_b), 32'd10);
    chk("illegal_not_counted", 32'(instret_a), 32'd0);
    cyc(1'b1, OP_R);
    chk("halt_sticky", 32'(state_b), 32'd10);

    // Counter wrap with the 4-bit instance.
    rst_n = 1'b0;
    cyc(1'b1, OP_R);
    rst_n = 1'b1;
    cyc(1'b1, OP_R);
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 4; k++) cyc(1'b1, OP_R);
    end
    chk("wrap_instret_a", 32'(instret_a), 32'd0);
    chk("wrap_instret_b", instret_b, 32'd16);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      logic [6:0] op;
      logic       mr;
      int         r;
      op = opcode;
      if (m_st[0] == 1) begin
        r = $urandom_range(0, 9);
        if (r <= 2)      op = OP_R;
        else if (r <= 4) op = OP_LW;
        else if (r <= 6) op = OP_SW;
        else if (r <= 8) op = OP_BEQ;
        else             op = ill_list[$urandom_range(0, 3)];
      end
      mr = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      cyc(mr, op);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
